// File: rtl/rf_seq_pkg.sv
// Shared opcodes, FSM state encoding and instruction field positions for the register-op sequencer.
package rf_seq_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_AND = 4'h3;
  localparam logic [3:0] OP_OR  = 4'h4;
  localparam logic [3:0] OP_XOR = 4'h5;
  localparam logic [3:0] OP_MOV = 4'h6;
  localparam logic [3:0] OP_LDI = 4'h7;
  localparam logic [3:0] OP_SHL = 4'h8;
  localparam logic [3:0] OP_SHR = 4'h9;

  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_e;

  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 9;
  localparam int RA_MSB  = 8;
  localparam int RA_LSB  = 6;
  localparam int RB_MSB  = 5;
  localparam int RB_LSB  = 3;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

endpackage

// File: rtl/rf_seq_alu.sv
// Combinational ALU: result, carry/borrow, write-intent and illegal-opcode decode.
// Zero latency; no flow control.
module rf_seq_alu
  import rf_seq_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] imm,
  output logic [DATA_W-1:0] result,
  output logic              c,
  output logic              writes,
  output logic              illegal
);

  logic [DATA_W:0] wide;

  always_comb begin
    result  = '0;
    c       = 1'b0;
    writes  = 1'b1;
    illegal = 1'b0;
    wide    = '0;
    case (op)
      OP_NOP: writes = 1'b0;
      OP_ADD: begin
        wide   = {1'b0, a} + {1'b0, b};
        result = wide[DATA_W-1:0];
        c      = wide[DATA_W];
      end
      // Top bit of the extended difference is the unsigned borrow (a < b).
      OP_SUB: begin
        wide   = {1'b0, a} - {1'b0, b};
        result = wide[DATA_W-1:0];
        c      = wide[DATA_W];
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_MOV: result = a;
      OP_LDI: result = imm;
      OP_SHL: begin
        result = {a[DATA_W-2:0], 1'b0};
        c      = a[DATA_W-1];
      end
      OP_SHR: begin
        result = {1'b0, a[DATA_W-1:1]};
        c      = a[0];
      end
      default: begin
        writes  = 1'b0;
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/rf_op_sequencer.sv
// Register-file op sequencer: IDLE->READ->EXEC->WB, writeback/done in the 4th cycle after accept.
// One instruction per 4 cycles; instr_ready only in IDLE, R0 writes suppressed.
module rf_op_sequencer
  import rf_seq_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  input  logic [15:0]       instr,
  output logic              instr_ready,
  output logic [ADDR_W-1:0] rf_aa,
  output logic [ADDR_W-1:0] rf_ba,
  input  logic [DATA_W-1:0] rf_data_a,
  input  logic [DATA_W-1:0] rf_data_b,
  output logic              rf_wr,
  output logic [ADDR_W-1:0] rf_da,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              flag_z,
  output logic              flag_n,
  output logic              flag_c,
  output logic              done,
  output logic              illegal
  ,
  output logic              r0_blocked
);

  state_e              state_q, state_d;
  logic                live_q;
  logic [15:0]         instr_q, instr_d;
  logic [DATA_W-1:0]   opa_q, opa_d, opb_q, opb_d;
  logic [ADDR_W-1:0]   aa_q, aa_d, ba_q, ba_d, da_q, da_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                wr_q, wr_d, done_q, done_d, ill_q, ill_d, r0_q, r0_d;
  logic                z_q, z_d, n_q, n_d, c_q, c_d;
  logic                accept, rd_zero;
  logic [DATA_W-1:0]   alu_result;
  logic                alu_c, alu_writes, alu_illegal;

  rf_seq_alu #(.DATA_W(DATA_W)) u_alu (
    .op      (instr_q[OP_MSB:OP_LSB]),
    .a       (opa_q),
    .b       (opb_q),
    .imm     (instr_q[IMM_MSB:IMM_LSB]),
    .result  (alu_result),
    .c       (alu_c),
    .writes  (alu_writes),
    .illegal (alu_illegal)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = READ;
      READ:    state_d = EXEC;
      EXEC:    state_d = WB;
      default: state_d = IDLE;
    endcase
  end

  // live_q keeps instr_ready low while reset is asserted.
  always_comb begin
    instr_ready = (state_q == IDLE) && live_q;
    accept      = instr_ready && instr_valid;
  end

  assign rd_zero = (instr_q[RD_MSB:RD_LSB] == 3'd0);

  always_comb begin
    instr_d = instr_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    aa_d    = aa_q;
    ba_d    = ba_q;
    da_d    = da_q;
    wdata_d = wdata_q;
    z_d     = z_q;
    n_d     = n_q;
    c_d     = c_q;
    wr_d    = 1'b0;
    done_d  = 1'b0;
    ill_d   = 1'b0;
    r0_d    = 1'b0;
    case (state_q)
      IDLE: if (accept) begin
        instr_d = instr;
        aa_d    = instr[RA_MSB:RA_LSB];
        ba_d    = instr[RB_MSB:RB_LSB];
      end
      READ: begin
        opa_d = rf_data_a;
        opb_d = rf_data_b;
      end
      EXEC: begin
        da_d    = instr_q[RD_MSB:RD_LSB];
        wdata_d = alu_result;
        wr_d    = alu_writes && !rd_zero;
        r0_d    = alu_writes && rd_zero;
        ill_d   = alu_illegal;
        done_d  = 1'b1;
        if (alu_writes) begin
          z_d = (alu_result == '0);
          n_d = alu_result[DATA_W-1];
          c_d = alu_c;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      live_q  <= 1'b0;
      instr_q <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      aa_q    <= '0;
      ba_q    <= '0;
      da_q    <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      done_q  <= 1'b0;
      ill_q   <= 1'b0;
      r0_q    <= 1'b0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
      c_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      live_q  <= 1'b1;
      instr_q <= instr_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      aa_q    <= aa_d;
      ba_q    <= ba_d;
      da_q    <= da_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      done_q  <= done_d;
      ill_q   <= ill_d;
      r0_q    <= r0_d;
      z_q     <= z_d;
      n_q     <= n_d;
      c_q     <= c_d;
    end
  end

  assign rf_aa      = aa_q;
  assign rf_ba      = ba_q;
  assign rf_da      = da_q;
  assign rf_wdata   = wdata_q;
  assign rf_wr      = wr_q;
  assign done       = done_q;
  assign illegal    = ill_q;
  assign r0_blocked = r0_q;
  assign flag_z     = z_q;
  assign flag_n     = n_q;
  assign flag_c     = c_q;

endmodule

// File: tb/tb_rf_op_sequencer.sv
// Directed bench for rf_op_sequencer with an 8x8 combinational-read register file model.
module tb_rf_op_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic [15:0] instr = 16'h0;
  logic        instr_ready;
  logic [2:0]  rf_aa, rf_ba, rf_da;
  logic [7:0]  rf_data_a, rf_data_b, rf_wdata;
  logic        rf_wr, flag_z, flag_n, flag_c, done, illegal, r0_blocked;

  logic [7:0]  rf [8];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          r0_viol = 0;

  logic        s_early, s_busy, s_done, s_wr, s_ill, s_r0;
  logic [2:0]  s_da;
  logic [7:0]  s_wd;

  always #5 clk = ~clk;

  rf_op_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .rf_aa       (rf_aa),
    .rf_ba       (rf_ba),
    .rf_data_a   (rf_data_a),
    .rf_data_b   (rf_data_b),
    .rf_wr       (rf_wr),
    .rf_da       (rf_da),
    .rf_wdata    (rf_wdata),
    .flag_z      (flag_z),
    .flag_n      (flag_n),
    .flag_c      (flag_c),
    .done        (done),
    .illegal     (illegal),
    .r0_blocked  (r0_blocked)
  );

  assign rf_data_a = rf[rf_aa];
  assign rf_data_b = rf[rf_ba];

  always @(posedge clk) begin
    if (rf_wr) begin
      if (rf_da == 3'd0) r0_viol++;
      else rf[rf_da] <= rf_wdata;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] enc(input logic [3:0] op, input logic [2:0] rd,
                                      input logic [2:0] ra, input logic [2:0] rb);
    return {op, rd, ra, rb, 3'b000};
  endfunction

  function automatic logic [15:0] ldi(input logic [2:0] rd, input logic [7:0] imm);
    return {4'h7, rd, 1'b0, imm};
  endfunction

  // Issues one instruction; returns with the bench at the negedge of the WB cycle.
  task automatic run(input logic [15:0] ins);
    int t = 0;
    while (!instr_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!instr_ready) chk("accept_timeout", 32'(instr_ready), 32'd1);
    instr       = ins;
    instr_valid = 1'b1;
    s_early     = 1'b0;
    s_busy      = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (k == 1) instr_valid = 1'b0;
      if (k < 3 && (done || rf_wr)) s_early = 1'b1;
      if (k < 3 && instr_ready) s_busy = 1'b1;
    end
    s_done = done;
    s_wr   = rf_wr;
    s_da   = rf_da;
    s_wd   = rf_wdata;
    s_ill  = illegal;
    s_r0   = r0_blocked;
  endtask

  initial begin
    int accepts, low_run, max_low, min_low, extra_evt;
    for (int i = 0; i < 8; i++) rf[i] = 8'h00;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(instr_ready), 32'd0);
    chk("rst_outs", {rf_wr, done, illegal, r0_blocked, flag_z, flag_n, flag_c}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_ready", 32'(instr_ready), 32'd1);

    // LDI / ADD giving 0x80
    run(ldi(3'd1, 8'h7F));
    chk("ldi1_wr", {s_wr, s_da, s_wd}, {1'b1, 3'd1, 8'h7F});
    run(ldi(3'd2, 8'h01));
    run(enc(4'h1, 3'd3, 3'd1, 3'd2));
    chk("add_latency", {s_early, s_done, s_busy}, {1'b0, 1'b1, 1'b0});
    chk("add_wr", {s_wr, s_da, s_wd}, {1'b1, 3'd3, 8'h80});
    chk("add_flags", {flag_z, flag_n, flag_c}, 3'b010);
    @(negedge clk);
    chk("add_rf3", rf[3], 8'h80);
    chk("ready_n4", 32'(instr_ready), 32'd1);

    // Carry out and borrow
    run(ldi(3'd1, 8'hFF));
    run(ldi(3'd2, 8'h01));
    run(enc(4'h1, 3'd4, 3'd1, 3'd2));
    chk("add_wrap", {s_wr, s_da, s_wd}, {1'b1, 3'd4, 8'h00});
    chk("add_wrap_flags", {flag_z, flag_n, flag_c}, 3'b101);
    run(enc(4'h2, 3'd5, 3'd2, 3'd1));
    chk("sub_borrow", {s_wd, flag_z, flag_n, flag_c}, {8'h02, 3'b001});

    // Write to R0: flags update, write suppressed
    run(enc(4'h1, 3'd0, 3'd1, 3'd2));
    chk("r0_pulse", {s_done, s_wr, s_r0, s_ill}, 4'b1010);
    chk("r0_flags", {flag_z, flag_n, flag_c}, 3'b101);

    // Shifts and a logic op
    run(enc(4'h8, 3'd7, 3'd1, 3'd0));
    chk("shl", {s_wd, flag_z, flag_n, flag_c}, {8'hFE, 3'b011});
    run(enc(4'h9, 3'd7, 3'd2, 3'd0));
    chk("shr", {s_wd, flag_z, flag_n, flag_c}, {8'h00, 3'b101});
    run(enc(4'h5, 3'd6, 3'd1, 3'd1));
    chk("xor_same", {s_wr, s_wd, flag_z, flag_n, flag_c}, {1'b1, 8'h00, 3'b100});

    // Illegal opcode leaves flags alone
    run(enc(4'h2, 3'd6, 3'd1, 3'd2));
    chk("sub_fe", {s_wd, flag_z, flag_n, flag_c}, {8'hFE, 3'b010});
    run(enc(4'hC, 3'd6, 3'd1, 3'd2));
    chk("illegal_pulse", {s_done, s_wr, s_ill, s_r0}, 4'b1010);
    chk("illegal_flags", {flag_z, flag_n, flag_c}, 3'b010);
    @(negedge clk);
    chk("illegal_ready_n4", 32'(instr_ready), 32'd1);
    chk("illegal_rf6", rf[6], 8'hFE);

    // Continuous valid: one accept every 4 cycles
    instr       = 16'h0000;
    instr_valid = 1'b1;
    accepts = 0; low_run = 0; max_low = 0; min_low = 99;
    for (int i = 0; i < 20; i++) begin
      if (instr_ready) begin
        accepts++;
        if (i > 0) begin
          if (low_run > max_low) max_low = low_run;
          if (low_run < min_low) min_low = low_run;
        end
        low_run = 0;
      end else begin
        low_run++;
      end
      @(negedge clk);
    end
    instr_valid = 1'b0;
    chk("stream_accepts", accepts, 5);
    chk("stream_low_run", {max_low[7:0], min_low[7:0]}, {8'd3, 8'd3});

    // Reset during EXEC abandons the instruction
    while (!instr_ready) @(negedge clk);
    instr       = enc(4'h1, 3'd3, 3'd1, 3'd2);
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_outs", {rf_wr, done, flag_z, flag_n, flag_c, rf_aa, rf_ba, instr_ready},
        32'd0);
    extra_evt = 0;
    repeat (2) begin
      @(negedge clk);
      if (rf_wr || done) extra_evt++;
    end
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (rf_wr || done) extra_evt++;
    end
    chk("mid_rst_no_evt", extra_evt, 0);
    chk("mid_rst_rf3", rf[3], 8'h80);
    chk("mid_rst_ready", 32'(instr_ready), 32'd1);

    chk("r0_never_written", {r0_viol[7:0], rf[0]}, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
